// File: rtl/beam_trigger_ctrl.sv
// ---------------------------------------------------------------------------
// beam_trigger_ctrl
//
// Trigger scheduler for the per-beam threshold comparators. Rising edges on
// the beam hit levels are qualified by a mask and a per-beam holdoff, parked
// as pending triggers with a captured timestamp, and serialized through a
// single valid/ready output slot by a round-robin arbiter. Edges that arrive
// while the same beam is already pending are counted as drops.
//
// Build option:
//   BEAM_TRIG_DROPCNT_EN  defined   -> saturating 16-bit drop counter built
//                         undefined -> no counter logic, drop_count tied to 0
//
// Parameters:
//   NBEAM      number of beam hit inputs (2..64)
//   HOLD_BITS  width of the holdoff register and per-beam holdoff counters
//   TS_BITS    width of the free-running timestamp
//
// Ports:
//   clk         system clock
//   rst         synchronous, active-high reset
//   beam_hit    per-beam comparator outputs (level)
//   cfg_wr      one-cycle config write strobe
//   cfg_addr    0 = mask register, 1 = holdoff register
//   cfg_data    write data (holdoff uses the low HOLD_BITS bits)
//   trig_valid  output slot holds a trigger
//   trig_ready  downstream accepts the trigger
//   trig_beam   index of the triggered beam
//   trig_time   timestamp captured at the hit edge
//   drop_count  saturating count of hits lost to an already-pending beam
// ---------------------------------------------------------------------------
module beam_trigger_ctrl #(
  parameter int NBEAM     = 16,
  parameter int HOLD_BITS = 8,
  parameter int TS_BITS   = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NBEAM-1:0]         beam_hit,
  input  logic                     cfg_wr,
  input  logic                     cfg_addr,
  input  logic [NBEAM-1:0]         cfg_data,
  output logic                     trig_valid,
  input  logic                     trig_ready,
  output logic [$clog2(NBEAM)-1:0] trig_beam,
  output logic [TS_BITS-1:0]       trig_time,
  output logic [15:0]              drop_count
);

  localparam int BW = $clog2(NBEAM);
  localparam int SW = BW + 1;  // scan index needs one spare bit for the wrap

  // Registered state
  logic [TS_BITS-1:0]   ts;
  logic [NBEAM-1:0]     hit_q;
  logic [NBEAM-1:0]     mask;
  logic [HOLD_BITS-1:0] holdoff;
  logic [NBEAM-1:0]     pend;
  logic [TS_BITS-1:0]   pts      [NBEAM];
  logic [HOLD_BITS-1:0] hold_cnt [NBEAM];
  logic [BW-1:0]        rr_ptr;

  // Combinational decode
  logic [NBEAM-1:0]     hold_zero;
  logic [NBEAM-1:0]     hit_edge;
  logic [NBEAM-1:0]     qual;
  logic [NBEAM-1:0]     set_req;
  logic [NBEAM-1:0]     grant_vec;
  logic [NBEAM-1:0]     pend_nxt;
  logic                 slot_free;
  logic                 pend_hit;
  logic                 grant;
  logic [BW-1:0]        grant_idx;
  logic [BW-1:0]        rr_nxt;
  logic [SW-1:0]        scan_idx;
  logic                 mask_wr;
  logic                 hold_wr;

  assign mask_wr = cfg_wr & ~cfg_addr;
  assign hold_wr = cfg_wr & cfg_addr;

  always_comb begin
    for (int i = 0; i < NBEAM; i++) begin
      hold_zero[i] = (hold_cnt[i] == '0);
    end
  end

  // A held-high level produces exactly one edge.
  assign hit_edge = beam_hit & ~hit_q;
  assign qual     = hit_edge & ~mask & hold_zero;
  assign set_req  = qual & ~pend;

  assign slot_free = ~trig_valid | trig_ready;

  // Round-robin search: first pending beam at or above rr_ptr, wrapping.
  always_comb begin
    // NOTE: every variable written here gets a default first, so no path
    // through the loop can leave it unassigned and infer a latch.
    pend_hit  = 1'b0;
    grant_idx = '0;
    scan_idx  = '0;
    for (int k = 0; k < NBEAM; k++) begin
      scan_idx = {1'b0, rr_ptr} + SW'(k);
      if (scan_idx >= SW'(NBEAM)) scan_idx = scan_idx - SW'(NBEAM);
      if (!pend_hit && pend[scan_idx[BW-1:0]]) begin
        pend_hit  = 1'b1;
        grant_idx = scan_idx[BW-1:0];
      end
    end
  end

  assign grant     = slot_free & pend_hit;
  assign grant_vec = grant ? (NBEAM'(1) << grant_idx) : '0;
  assign rr_nxt    = (grant_idx == BW'(NBEAM - 1)) ? '0 : grant_idx + 1'b1;

  // A beam granted this cycle still reads as pending to its own edge, so a
  // coinciding edge is a drop (set_req excludes it). A mask write clears the
  // newly masked beams last, so it wins over a same-cycle pending-set.
  always_comb begin
    pend_nxt = (pend | set_req) & ~grant_vec;
    if (mask_wr) pend_nxt = pend_nxt & ~cfg_data;
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values no matter the statement order.
    if (rst) begin
      ts         <= '0;
      hit_q      <= '0;
      mask       <= '1;
      holdoff    <= '0;
      pend       <= '0;
      rr_ptr     <= '0;
      trig_valid <= 1'b0;
      trig_beam  <= '0;
      trig_time  <= '0;
      for (int i = 0; i < NBEAM; i++) hold_cnt[i] <= '0;
    end else begin
      ts    <= ts + 1'b1;
      hit_q <= beam_hit;
      pend  <= pend_nxt;
      if (mask_wr) mask    <= cfg_data;
      if (hold_wr) holdoff <= HOLD_BITS'(cfg_data);

      // A grant reloads from the register value before any same-cycle write.
      for (int i = 0; i < NBEAM; i++) begin
        if (grant_vec[i])       hold_cnt[i] <= holdoff;
        else if (!hold_zero[i]) hold_cnt[i] <= hold_cnt[i] - 1'b1;
      end

      if (grant) begin
        trig_valid <= 1'b1;
        trig_beam  <= grant_idx;
        trig_time  <= pts[grant_idx];
        rr_ptr     <= rr_nxt;
      end else if (slot_free) begin
        trig_valid <= 1'b0;
      end
    end
  end

  // NOTE: pts is intentionally not reset; an entry is only read while its
  // pend bit is set, and pend itself is reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NBEAM; i++) begin
      if (set_req[i]) pts[i] <= ts;
    end
  end

`ifdef BEAM_TRIG_DROPCNT_EN
  localparam int CW = $clog2(NBEAM + 1);

  logic [NBEAM-1:0] drop_req;
  logic [CW-1:0]    drop_pop;
  logic [16:0]      drop_sum;

  assign drop_req = qual & pend;

  always_comb begin
    drop_pop = '0;
    for (int i = 0; i < NBEAM; i++) drop_pop = drop_pop + CW'(drop_req[i]);
  end

  assign drop_sum = {1'b0, drop_count} + 17'(drop_pop);

  always_ff @(posedge clk) begin
    if (rst)              drop_count <= '0;
    else if (drop_sum[16]) drop_count <= 16'hFFFF;
    else                  drop_count <= drop_sum[15:0];
  end
`else
  assign drop_count = '0;
`endif

endmodule

// File: tb/tb_beam_trigger_ctrl.sv
// ---------------------------------------------------------------------------
// tb_beam_trigger_ctrl
//
// Scoreboard bench for beam_trigger_ctrl. A behavioural model steps once per
// clock from the same inputs and pushes each trigger it grants into exp_q; a
// monitor on the falling edge compares the presented trigger against the
// queue head and pops it on a handshake. Directed scenarios are followed by
// a randomized phase.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_beam_trigger_ctrl;

  localparam int NBEAM = 16;

`ifdef BEAM_TRIG_DROPCNT_EN
  localparam int EXP_DROP3  = 3;
  localparam int EXP_DROPSAT = 65535;
  localparam bit DROP_EN    = 1'b1;
`else
  localparam int EXP_DROP3  = 0;
  localparam int EXP_DROPSAT = 0;
  localparam bit DROP_EN    = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] beam_hit;
  logic        cfg_wr;
  logic        cfg_addr;
  logic [15:0] cfg_data;
  logic        trig_valid;
  logic        trig_ready;
  logic [3:0]  trig_beam;
  logic [15:0] trig_time;
  logic [15:0] drop_count;

  beam_trigger_ctrl #(.NBEAM(16), .HOLD_BITS(8), .TS_BITS(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .beam_hit   (beam_hit),
    .cfg_wr     (cfg_wr),
    .cfg_addr   (cfg_addr),
    .cfg_data   (cfg_data),
    .trig_valid (trig_valid),
    .trig_ready (trig_ready),
    .trig_beam  (trig_beam),
    .trig_time  (trig_time),
    .drop_count (drop_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  bit mon_en   = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int beam;
    int tstamp;
  } trig_t;

  trig_t      exp_q[$];
  int         acc_q[$];
  int         m_ts;
  bit [15:0]  m_hitq;
  bit [15:0]  m_mask;
  int         m_hold;
  bit         m_pend [NBEAM];
  int         m_pts  [NBEAM];
  int         m_hcnt [NBEAM];
  int         m_rr;
  bit         m_valid;
  int         m_drop;

  always @(posedge clk) begin
    if (rst) begin
      m_ts = 0; m_hitq = '0; m_mask = '1; m_hold = 0; m_rr = 0;
      m_valid = 1'b0; m_drop = 0;
      exp_q.delete();
      for (int i = 0; i < NBEAM; i++) begin
        m_pend[i] = 1'b0;
        m_hcnt[i] = 0;
      end
    end else begin
      automatic bit        free  = !m_valid || trig_ready;
      automatic int        g     = -1;
      automatic int        drops = 0;
      automatic bit [15:0] newp  = '0;
      if (free) begin
        for (int k = 0; k < NBEAM; k++) begin
          automatic int b = (m_rr + k) % NBEAM;
          if (g < 0 && m_pend[b]) g = b;
        end
      end
      for (int i = 0; i < NBEAM; i++) begin
        if (beam_hit[i] && !m_hitq[i] && !m_mask[i] && m_hcnt[i] == 0) begin
          if (m_pend[i]) drops++;
          else newp[i] = 1'b1;
        end
        if (m_hcnt[i] > 0) m_hcnt[i]--;
      end
      for (int i = 0; i < NBEAM; i++) begin
        if (newp[i]) begin
          m_pend[i] = 1'b1;
          m_pts[i]  = m_ts;
        end
      end
      if (g >= 0) begin
        trig_t t;
        t.beam   = g;
        t.tstamp = m_pts[g];
        exp_q.push_back(t);
        m_pend[g] = 1'b0;
        m_hcnt[g] = m_hold;
        m_valid   = 1'b1;
        m_rr      = (g + 1) % NBEAM;
      end else if (free) begin
        m_valid = 1'b0;
      end
      if (cfg_wr && !cfg_addr) begin
        for (int i = 0; i < NBEAM; i++) if (cfg_data[i]) m_pend[i] = 1'b0;
        m_mask = cfg_data;
      end
      if (cfg_wr && cfg_addr) m_hold = int'(cfg_data[7:0]);
      if (DROP_EN) m_drop = (m_drop + drops > 65535) ? 65535 : m_drop + drops;
      m_hitq = beam_hit;
      m_ts   = (m_ts + 1) % 65536;
    end
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (mon_en) begin
      check("trig_valid", trig_valid, m_valid);
      check("drop_count", drop_count, m_drop);
      if (trig_valid && m_valid) begin
        check("exp_queue_depth", exp_q.size(), 1);
        if (exp_q.size() > 0) begin
          check("trig_beam", trig_beam, exp_q[0].beam);
          check("trig_time", trig_time, exp_q[0].tstamp);
          if (trig_ready) begin
            acc_q.push_back(int'(trig_beam));
            void'(exp_q.pop_front());
          end
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic cfg_write(input logic addr, input logic [15:0] data);
    cfg_wr   = 1'b1;
    cfg_addr = addr;
    cfg_data = data;
    tick();
    cfg_wr   = 1'b0;
  endtask

  task automatic check_order(input string name, input int e0, input int e1, input int e2);
    check({name, "_count"}, acc_q.size(), 3);
    if (acc_q.size() == 3) begin
      check({name, "_0"}, acc_q[0], e0);
      check({name, "_1"}, acc_q[1], e1);
      check({name, "_2"}, acc_q[2], e2);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  initial begin
    int t2;
    rst        = 1'b1;
    beam_hit   = '0;
    cfg_wr     = 1'b0;
    cfg_addr   = 1'b0;
    cfg_data   = '0;
    trig_ready = 1'b1;
    tick();
    tick();
    rst    = 1'b0;
    mon_en = 1'b1;

    // Reset state
    check("rst_valid", trig_valid, 0);
    check("rst_beam", trig_beam, 0);
    check("rst_time", trig_time, 0);
    check("rst_drop", drop_count, 0);

    // All beams masked out of reset
    beam_hit = 16'h0008;
    tick();
    beam_hit = '0;
    repeat (4) tick();
    check("masked_no_trig", trig_valid, 0);

    // Unmask beam 3, hit at ts = 0x40
    cfg_write(1'b0, 16'hFFF7);
    for (int n = 0; n < 200 && m_ts != 'h40; n++) tick();
    if (m_ts != 'h40) check("ts_align_timeout", m_ts, 'h40);
    beam_hit = 16'h0008;
    tick();
    beam_hit = '0;
    tick();
    check("first_valid", trig_valid, 1);
    check("first_beam", trig_beam, 3);
    check("first_time", trig_time, 16'h0040);
    tick();

    // Round-robin from rr_ptr = 0
    do_reset();
    cfg_write(1'b0, 16'h0000);
    trig_ready = 1'b0;
    acc_q.delete();
    beam_hit = 16'h0222;
    tick();
    beam_hit = '0;
    repeat (5) tick();
    trig_ready = 1'b1;
    repeat (5) tick();
    check_order("rr_a", 1, 5, 9);

    // Move rr_ptr to 6, then repeat
    beam_hit = 16'h0020;
    tick();
    beam_hit = '0;
    repeat (4) tick();
    acc_q.delete();
    trig_ready = 1'b0;
    beam_hit = 16'h0222;
    tick();
    beam_hit = '0;
    repeat (5) tick();
    trig_ready = 1'b1;
    repeat (5) tick();
    check_order("rr_b", 9, 1, 5);

    // Backpressure: beam 2 held, beam 4 waits
    trig_ready = 1'b0;
    t2 = m_ts;
    beam_hit = 16'h0004;
    tick();
    beam_hit = '0;
    tick();
    beam_hit = 16'h0010;
    tick();
    beam_hit = '0;
    for (int n = 0; n < 10; n++) begin
      check("bp_valid", trig_valid, 1);
      check("bp_beam", trig_beam, 2);
      check("bp_time", trig_time, t2);
      tick();
    end
    trig_ready = 1'b1;
    tick();
    check("bp_next_valid", trig_valid, 1);
    check("bp_next_beam", trig_beam, 4);
    repeat (3) tick();

    // Holdoff = 5: edges at G+3 and G+5 ignored
    cfg_write(1'b1, 16'h0005);
    acc_q.delete();
    beam_hit = 16'h0001;
    tick();                       // cycle G
    beam_hit = '0;
    repeat (3) tick();            // G+3
    beam_hit = 16'h0001;
    tick();                       // G+4
    beam_hit = '0;
    tick();                       // G+5
    beam_hit = 16'h0001;
    tick();
    beam_hit = '0;
    repeat (8) tick();
    check("hold_ignored_count", acc_q.size(), 1);

    // Edge at G+6 is accepted
    beam_hit = 16'h0001;
    tick();                       // cycle G
    beam_hit = '0;
    repeat (6) tick();            // G+6
    beam_hit = 16'h0001;
    tick();
    beam_hit = '0;
    repeat (6) tick();
    check("hold_expired_count", acc_q.size(), 3);
    cfg_write(1'b1, 16'h0000);

    // Drops: slot held by beam 6, beam 7 pulsed four times
    do_reset();
    cfg_write(1'b0, 16'h0000);
    trig_ready = 1'b0;
    beam_hit = 16'h0040;
    tick();
    beam_hit = '0;
    repeat (2) tick();
    for (int n = 0; n < 4; n++) begin
      beam_hit = 16'h0080;
      tick();
      beam_hit = '0;
      tick();
    end
    tick();
    check("drop_three", drop_count, EXP_DROP3);

    // Saturation
    for (int n = 0; n < 4200; n++) begin
      beam_hit = 16'hFFFF;
      tick();
      beam_hit = '0;
      tick();
    end
    tick();
    check("drop_saturate", drop_count, EXP_DROPSAT);

    // Mask-clear of a pending beam, and mask-clear beating a same-cycle set
    do_reset();
    cfg_write(1'b0, 16'h0000);
    trig_ready = 1'b0;
    beam_hit = 16'h0002;
    tick();
    beam_hit = '0;
    repeat (2) tick();
    beam_hit = 16'h1000;
    tick();
    beam_hit = '0;
    tick();
    acc_q.delete();
    beam_hit = 16'h2000;
    cfg_write(1'b0, 16'h3000);
    beam_hit = '0;
    trig_ready = 1'b1;
    repeat (6) tick();
    check("maskclr_count", acc_q.size(), 1);
    if (acc_q.size() > 0) check("maskclr_beam", acc_q[0], 1);

    // Reset while a trigger is held
    trig_ready = 1'b0;
    beam_hit = 16'h0008;
    tick();
    beam_hit = '0;
    repeat (2) tick();
    for (int n = 0; n < 2; n++) begin
      beam_hit = 16'h0010;
      tick();
      beam_hit = '0;
      tick();
    end
    check("midrst_pre_valid", trig_valid, 1);
    check("midrst_pre_drop", drop_count, DROP_EN ? 1 : 0);
    rst = 1'b1;
    tick();
    check("midrst_valid", trig_valid, 0);
    check("midrst_drop", drop_count, 0);
    tick();
    rst = 1'b0;

    // Randomized traffic
    cfg_write(1'b0, 16'($urandom) & 16'h0FF0);
    cfg_write(1'b1, 16'($urandom_range(0, 3)));
    for (int n = 0; n < 3000; n++) begin
      beam_hit   = 16'($urandom) & 16'($urandom) & 16'($urandom);
      trig_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 49) == 0) begin
        cfg_wr   = 1'b1;
        cfg_addr = 1'($urandom_range(0, 1));
        cfg_data = cfg_addr ? 16'($urandom_range(0, 6)) : 16'($urandom);
      end else begin
        cfg_wr = 1'b0;
      end
      tick();
    end
    cfg_wr     = 1'b0;
    beam_hit   = '0;
    trig_ready = 1'b1;
    repeat (40) tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
